// File: rtl/aemb_intc_pkg.sv
// Shared register map and IVR layout for the aeMB interrupt controller.
package aemb_intc_pkg;

  typedef enum logic [2:0] {
    REG_ISR = 3'd0,
    REG_IER = 3'd1,
    REG_IPR = 3'd2,
    REG_IVR = 3'd3,
    REG_MER = 3'd4
  } reg_addr_e;

  localparam int IVR_VALID_BIT = 31;
  localparam int IVR_IDX_W     = 5;

  // Expands the four byte-lane enables into a 32-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/aemb_intc_if.sv
// Wishbone-classic data-bus bundle between the aeMB core and the interrupt controller.
interface aemb_intc_if;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [2:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/aemb_intc_sync.sv
// Per-source two-flop synchroniser plus history flop; exposes the synchronised level and its rising edge.
module aemb_intc_sync #(
  parameter int NIRQ = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq,
  output logic [NIRQ-1:0] lvl,
  output logic [NIRQ-1:0] rise
);

  logic [NIRQ-1:0] s1, s2, p;

  // NOTE: sequential state uses non-blocking assignments so each flop samples its pre-edge source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      p  <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~p;

endmodule

// File: rtl/aemb_intc.sv
// Wishbone-classic interrupt controller: status/enable/master-enable registers, priority vector,
// and a registered level interrupt to the aeMB core.
module aemb_intc
  import aemb_intc_pkg::*;
#(
  parameter int              NIRQ = 8,
  parameter logic [NIRQ-1:0] EDGE = {NIRQ{1'b1}}
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  aemb_intc_if.slave      wb,
  input  logic [NIRQ-1:0] irq_i,
  output logic            sys_int_o
);

  logic [NIRQ-1:0] isr, ier, ipr, lvl, rise, clr, isr_next, ier_next;
  logic            mer;
  logic            access, wr, wr_isr, wr_ier, wr_mer;
  logic [31:0]     wmask, wbits, ivr, rd_mux;
  logic [IVR_IDX_W-1:0] idx;

  aemb_intc_sync #(.NIRQ(NIRQ)) u_sync (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_i),
    .irq   (irq_i),
    .lvl   (lvl),
    .rise  (rise)
  );

  // A transfer is live only on the first cycle STB is seen; the ACK cycle itself does nothing.
  assign access = wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr     = access & wb.wb_we_i;
  assign wr_isr = wr && (wb.wb_adr_i == REG_ISR);
  assign wr_ier = wr && (wb.wb_adr_i == REG_IER);
  assign wr_mer = wr && (wb.wb_adr_i == REG_MER);

  assign wmask = lane_mask(wb.wb_sel_i);
  assign wbits = wb.wb_dat_i & wmask;

  // A same-edge rise beats a W1C clear; level bits simply track the synchronised input.
  assign clr      = wr_isr ? NIRQ'(wbits) : '0;
  assign isr_next = (EDGE & ((isr & ~clr) | rise)) | (~EDGE & lvl);
  assign ier_next = wr_ier ? ((ier & ~NIRQ'(wmask)) | NIRQ'(wbits)) : ier;

  assign ipr = isr & ier;

  always_comb begin
    idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (ipr[i]) idx = IVR_IDX_W'(i);
    end
  end

  always_comb begin
    ivr                  = '0;
    ivr[IVR_VALID_BIT]   = |ipr;
    ivr[IVR_IDX_W-1:0]   = idx;
  end

  always_comb begin
    rd_mux = '0;
    case (wb.wb_adr_i)
      REG_ISR: rd_mux = 32'(isr);
      REG_IER: rd_mux = 32'(ier);
      REG_IPR: rd_mux = 32'(ipr);
      REG_IVR: rd_mux = ivr;
      REG_MER: rd_mux = {31'b0, mer};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      isr         <= '0;
      ier         <= '0;
      mer         <= 1'b0;
      sys_int_o   <= 1'b0;
    end else begin
      wb.wb_ack_o <= access;
      wb.wb_dat_o <= (access & ~wb.wb_we_i) ? rd_mux : '0;
      isr         <= isr_next;
      ier         <= ier_next;
      if (wr_mer && wb.wb_sel_i[0]) mer <= wb.wb_dat_i[0];
      sys_int_o   <= mer & |ipr;
    end
  end

endmodule

// File: doc/aemb_intc.md
Name: aemb_intc

Overview:
- Wishbone-classic slave interrupt controller on the aeMB data bus.
- It aggregates NIRQ peripheral interrupt lines into the single level interrupt that the core's system-control unit samples as sys_int_i; the core gates that input with MSR[IE].
- It is the responder side of the core's data-bus handshake: the core holds STB until ACK, so this block must return exactly one ACK per strobe.

Parameters:
- NIRQ, 8, number of interrupt sources, 1..32.
- EDGE, {NIRQ{1'b1}}, per-source mode: 1 = rising-edge latched, 0 = level (status follows the synchronised input).

Ports:
- sys_clk_i  in  1  single clock; all flops on rising edge.
- sys_rst_i  in  1  reset, asynchronous assert, active-low; deassertion is synchronised externally.
- wb_stb_i  in  1  bus strobe/cycle; held by the master until ACK.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  3  word address (byte address bits [4:2]).
- wb_sel_i  in  4  byte-lane enables for writes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_ack_o  out  1  transfer acknowledge.
- irq_i  in  NIRQ  asynchronous interrupt sources.
- sys_int_o  out  1  interrupt request to the core, registered.

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, sys_int_o=0, ISR=0, IER=0, MER=0, synchroniser and edge-history flops=0.
- Input path per source: 2-flop synchroniser s1/s2, then history flop p<=s2.
  - Edge source: rise = s2 & ~p sets ISR[i].
  - Level source: ISR[i] = s2 every cycle.
- Register map (wb_adr_i); unused bits and unused addresses read 0; writes to read-only locations are ignored.
  - 0 ISR: read status. Write-1-to-clear on edge bits; level bits ignore writes.
  - 1 IER: read/write enable mask, NIRQ bits.
  - 2 IPR: read-only, ISR & IER.
  - 3 IVR: read-only. Bit31 = |IPR; [4:0] = lowest-numbered set IPR bit (0 is highest priority); [4:0] = 0 when bit31 = 0.
  - 4 MER: bit0 = master enable, read/write via lane 0.
- Handshake: at each edge, wb_ack_o <= wb_stb_i & ~wb_ack_o.
  - ACK is a one-cycle pulse on the cycle after STB is first sampled.
  - Back-to-back strobes get ACK every other cycle.
  - If STB drops before ACK, no state changes; the cycle is abandoned.
- Write commit: on the same edge that raises ACK (stb & ~ack & we), honouring wb_sel_i per byte lane.
- Read data: registered on the same edge and presented with ACK. It reflects state before any same-edge update.
- Simultaneous events:
  - An edge rise and a W1C clear of the same ISR bit on the same edge: set wins, bit stays 1.
  - An IER or MER write and a pending change on the same edge: sys_int_o uses the pre-edge values, so the new value shows one cycle later.
- sys_int_o <= MER & |(ISR & IER), registered.
- Latency: irq_i sampled high at edge k gives ISR set after edge k+2 and sys_int_o high after edge k+3.
- Clearing: after the last pending bit is cleared, sys_int_o falls one edge after the clearing ACK edge.
- Edge pulses: a pulse narrower than one clock may be missed; a pulse of at least 2 clocks is guaranteed to be captured.
- Reset mid-transfer: ACK is forced low immediately. The in-flight transfer is lost, and the master must restart it.

Decomposition:
- Package aemb_intc_pkg holds:
  - register offset constants ISR=0, IER=1, IPR=2, IVR=3, MER=4;
  - the IVR valid-bit position 31;
  - the IVR index width 5.
- Sub-module aemb_intc_sync holds, per source, the synchroniser, history flop and rise output, with a NIRQ-wide vector.
- The top level holds the registers, bus logic and priority encoder (a for-loop scanning from high index to low so the lowest index wins).

Test Plan:
- Reset then read all five addresses -> ACK one cycle after STB each time; data 0; sys_int_o=0 throughout.
- Write IER=0x05, MER=1; pulse irq_i[2] high for 3 clocks at edge k -> ISR=0x04 after k+2; sys_int_o=1 after k+3; IVR reads 0x80000002.
- With ISR=0x0C pending and enabled, read IVR -> 0x80000002. Write ISR=0x04 -> IVR reads 0x80000003. Write ISR=0x08 -> sys_int_o low one edge after the ACK.
- Raise a fresh irq_i[2] edge timed to the same edge as the W1C write of 0x04 -> ISR[2] remains 1 and sys_int_o stays 1.
- Level source (EDGE[0]=0): hold irq_i[0] high, write ISR=0x01 -> bit stays 1. Drop irq_i[0] -> ISR[0]=0 two edges later.
- STB held continuously for 4 cycles -> ACK pattern 0,1,0,1. Assert sys_rst_i low while ACK is high -> ACK and sys_int_o go 0 asynchronously; IER and MER read 0 afterwards.
